// File: rtl/dbg_pkg.sv
// ---------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the UART-to-debug-port command controller:
//   - command byte codes (READ / WRITE)
//   - default ACK / ERR response bytes
//   - controller state enum
//   - is_cmd() helper used by the command decoder
// ---------------------------------------------------------------------------
package dbg_pkg;

    localparam logic [7:0] CMD_READ     = 8'h01;
    localparam logic [7:0] CMD_WRITE    = 8'h02;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAC;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        RESP  = 3'd5
    } dbg_state_e;

    // True for the two command codes the controller understands.
    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_READ) || (b == CMD_WRITE);
    endfunction

endpackage

// File: rtl/dbg_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// dbg_cmd_ctrl_if
// Bundles the three buses of the command controller:
//   rx_*   : byte strobe from the UART receiver (no back-pressure)
//   tx_*   : response bytes to the UART transmitter
//   dbg_*  : request/complete port to the core debug unit
// Modports:
//   master : the controller (drives tx_* and dbg_*_o)
//   slave  : the environment (UART + debug unit)
//
// Handshakes: rx_valid_i is a one-cycle strobe with no ready; the byte is
// consumed in that cycle or dropped. tx uses valid/ready: a byte transfers on
// every rising edge where tx_valid_o && tx_ready_i, and while tx_valid_o is
// high without tx_ready_i the offered byte does not change and valid does not
// drop. dbg uses valid/ready: dbg_valid_o plus all dbg_*_o stay constant until
// the edge where the controller sees dbg_ready_i in its WAIT state; ready seen
// in the same cycle valid first rises is not a completion.
// ---------------------------------------------------------------------------
interface dbg_cmd_ctrl_if;

    logic        rx_valid_i;
    logic [7:0]  rx_data_i;

    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;

    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic        dbg_valid_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;

    modport master (
        input  rx_valid_i, rx_data_i,
        input  tx_ready_i,
        input  dbg_data_i, dbg_ready_i,
        output tx_valid_o, tx_data_o,
        output dbg_cmd_o, dbg_addr_o, dbg_data_o, dbg_valid_o
    );

    modport slave (
        output rx_valid_i, rx_data_i,
        output tx_ready_i,
        output dbg_data_i, dbg_ready_i,
        input  tx_valid_o, tx_data_o,
        input  dbg_cmd_o, dbg_addr_o, dbg_data_o, dbg_valid_o
    );

endinterface

// File: rtl/dbg_resp_ser.sv
// ---------------------------------------------------------------------------
// dbg_resp_ser
// Response serializer: holds a 1- to 4-byte response and offers it MSB first
// on a valid/ready byte stream.
// Ports:
//   clk_i, rstn_i    clock, async active-low reset
//   load_i           load a new response (only issued while idle)
//   load_data_i      response, first byte in [31:24]
//   load_last_i      index of the last byte (0 = one byte, 3 = four bytes)
//   tx_ready_i       transmitter ready
//   tx_valid_o       byte offered
//   tx_data_o        current byte
//   last_hs_o        combinational: the last byte transfers this cycle
// ---------------------------------------------------------------------------
module dbg_resp_ser (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic [1:0]  load_last_i,
    input  logic        tx_ready_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    output logic        last_hs_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  rem_q, rem_d;     // bytes left after the current one
    logic        valid_q, valid_d;
    logic        hs;

    assign hs = valid_q && tx_ready_i;

    always_comb begin
        shift_d = shift_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = load_data_i;
            rem_d   = load_last_i;
            valid_d = 1'b1;
        end else if (hs) begin
            if (rem_q == 2'd0) begin
                valid_d = 1'b0;
                shift_d = '0;
            end else begin
                shift_d = {shift_q[23:0], 8'h00};
                rem_d   = rem_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shift_q <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
        end
    end

    assign tx_valid_o = valid_q;
    assign tx_data_o  = shift_q[31:24];
    assign last_hs_o  = hs && (rem_q == 2'd0);

endmodule

// File: rtl/dbg_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// dbg_cmd_ctrl
// Turns a UART byte stream into core debug-port requests.
// Frame: CMD (01 READ / 02 WRITE), 4 address bytes MSB first, and for WRITE
// 4 data bytes MSB first. READ answers with the 4 read-data bytes, WRITE with
// ACK_BYTE, any other command byte with ERR_BYTE. A frame that stalls for
// TIMEOUT_CYCLES between bytes is dropped without a response.
// Ports:
//   sys_clk_i, rstn_i  clock, async active-low reset
//   bus                dbg_cmd_ctrl_if.master (rx, tx, dbg buses)
//   state_o            current controller state, for observation
// ---------------------------------------------------------------------------
module dbg_cmd_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0]  ERR_BYTE       = ERR_BYTE_DEF
) (
    input  logic           sys_clk_i,
    input  logic           rstn_i,
    dbg_cmd_ctrl_if.master bus,
    output dbg_state_e     state_o
);

    localparam int unsigned IDLE_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ?
                                     $clog2(TIMEOUT_CYCLES + 1) : 16;
    // Idle-counter value at which one more empty cycle means timeout.
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    dbg_state_e        state_q;
    logic [7:0]        cmd_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        byte_cnt_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              dbg_valid_q;

    logic              ser_load;
    logic [31:0]       ser_data;
    logic [1:0]        ser_last;
    logic              ser_tx_valid;
    logic [7:0]        ser_tx_data;
    logic              ser_last_hs;

    // Response loads happen in the same edge that moves the FSM into RESP,
    // so tx_valid_o rises together with the state change.
    always_comb begin
        ser_load = 1'b0;
        ser_data = '0;
        ser_last = 2'd0;
        if (state_q == IDLE && bus.rx_valid_i && !is_cmd(bus.rx_data_i)) begin
            ser_load = 1'b1;
            ser_data = {ERR_BYTE, 24'h0};
        end else if (state_q == WAIT && bus.dbg_ready_i) begin
            ser_load = 1'b1;
            if (cmd_q == CMD_READ) begin
                ser_data = bus.dbg_data_i;
                ser_last = 2'd3;
            end else begin
                ser_data = {ACK_BYTE, 24'h0};
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.rx_valid_i) begin
                        if (is_cmd(bus.rx_data_i)) begin
                            cmd_q      <= bus.rx_data_i;
                            addr_q     <= '0;
                            wdata_q    <= '0;
                            byte_cnt_q <= '0;
                            idle_cnt_q <= '0;
                            state_q    <= ADDR;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end

                ADDR: begin
                    // A byte wins over a timeout that expires in the same cycle.
                    if (bus.rx_valid_i) begin
                        addr_q     <= {addr_q[23:0], bus.rx_data_i};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        idle_cnt_q <= '0;
                        if (byte_cnt_q == 2'd3) begin
                            if (cmd_q == CMD_READ) begin
                                dbg_valid_q <= 1'b1;
                                state_q     <= ISSUE;
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        idle_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (bus.rx_valid_i) begin
                        wdata_q    <= {wdata_q[23:0], bus.rx_data_i};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        idle_cnt_q <= '0;
                        if (byte_cnt_q == 2'd3) begin
                            dbg_valid_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        idle_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end

                // Ready in the first request cycle is not a completion: the
                // debug unit must see the request for at least one edge.
                ISSUE: begin
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (bus.dbg_ready_i) begin
                        dbg_valid_q <= 1'b0;
                        state_q     <= RESP;
                    end
                end

                RESP: begin
                    if (ser_last_hs) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    dbg_resp_ser u_ser (
        .clk_i       (sys_clk_i),
        .rstn_i      (rstn_i),
        .load_i      (ser_load),
        .load_data_i (ser_data),
        .load_last_i (ser_last),
        .tx_ready_i  (bus.tx_ready_i),
        .tx_valid_o  (ser_tx_valid),
        .tx_data_o   (ser_tx_data),
        .last_hs_o   (ser_last_hs)
    );

    assign bus.tx_valid_o  = ser_tx_valid;
    assign bus.tx_data_o   = ser_tx_data;
    assign bus.dbg_cmd_o   = cmd_q;
    assign bus.dbg_addr_o  = addr_q;
    assign bus.dbg_data_o  = wdata_q;
    assign bus.dbg_valid_o = dbg_valid_q;
    assign state_o         = state_q;

endmodule

// File: doc/dbg_cmd_ctrl.md
DBG_CMD_CTRL -- requirements
Module: dbg_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the maximum idle cycles between bytes of one frame.
REQ-002 SHALL have parameter ACK_BYTE, default 8'hAC, meaning the write-completion response byte.
REQ-003 SHALL have parameter ERR_BYTE, default 8'hEE, meaning the unknown-command response byte.
REQ-004 sys_clk_i  in  1  system clock; all logic is clocked on its rising edge.
REQ-005 rstn_i  in  1  reset; asynchronous, active-low.
REQ-006 rx_valid_i  in  1  one-cycle strobe: a received UART byte is present.
REQ-007 rx_data_i  in  8  received byte; valid only with rx_valid_i.
REQ-008 tx_valid_o  out  1  response byte offered to the UART transmitter.
REQ-009 tx_data_o  out  8  response byte.
REQ-010 tx_ready_i  in  1  transmitter accepts tx_data_o when tx_valid_o and tx_ready_i are both high.
REQ-011 dbg_cmd_o  out  8  command to the core debug port.
REQ-012 dbg_addr_o  out  32  debug address.
REQ-013 dbg_data_o  out  32  debug write data.
REQ-014 dbg_valid_o  out  1  debug request pending.
REQ-015 dbg_data_i  in  32  debug read data; valid with dbg_ready_i.
REQ-016 dbg_ready_i  in  1  debug request completed.

Function
REQ-017 SHALL implement states IDLE, ADDR, DATA, ISSUE, WAIT, RESP.
REQ-018 In IDLE, a byte 8'h01 (READ) or 8'h02 (WRITE) SHALL be latched as the command and move to ADDR; any other byte SHALL load ERR_BYTE into the response and move to RESP with a count of 1.
REQ-019 ADDR SHALL accept 4 bytes MSB-first into the address, then move to ISSUE for READ or DATA for WRITE.
REQ-020 DATA SHALL accept 4 bytes MSB-first into the write data, then move to ISSUE.
REQ-021 ISSUE SHALL assert dbg_valid_o for one cycle with dbg_cmd_o/dbg_addr_o/dbg_data_o stable, then move to WAIT.
REQ-022 WAIT SHALL hold dbg_valid_o high and all dbg_*_o stable until dbg_ready_i, including when dbg_ready_i is already high in the ISSUE cycle.
REQ-023 On dbg_ready_i, READ SHALL capture dbg_data_i as a 4-byte response, MSB first; WRITE SHALL load a 1-byte response of ACK_BYTE; then move to RESP.
REQ-024 RESP SHALL hold tx_valid_o high with the current byte, advance one byte per tx handshake, and return to IDLE after the last handshake.
REQ-025 tx_data_o SHALL NOT change while tx_valid_o is high and tx_ready_i is low.
REQ-026 rx bytes arriving in ISSUE, WAIT or RESP SHALL be discarded without effect.
REQ-027 In ADDR or DATA, a 16-bit-or-wider idle counter SHALL clear on every accepted byte; reaching TIMEOUT_CYCLES SHALL abort to IDLE silently, with no debug request and no response.
REQ-028 A byte accepted in the same cycle the counter reaches TIMEOUT_CYCLES SHALL be taken and SHALL NOT cause an abort.
REQ-029 The byte counter SHALL be 2 bits and wrap 3 to 0 at each field end.
REQ-030 Throughput SHALL be one rx byte per cycle; the first tx_valid_o SHALL rise no later than 1 cycle after dbg_ready_i.

Reset
REQ-031 While rstn_i is low, the block SHALL be in IDLE with all outputs, counters and shift registers at 0.
REQ-032 Reset mid-frame or mid-response SHALL abandon the transaction; the first byte after release SHALL be decoded as a command.

Structure
REQ-033 Command codes, ACK/ERR defaults and the state enum typedef SHALL live in the shared package dbg_pkg.
REQ-034 A single sub-module dbg_resp_ser SHALL hold the 1-to-4-byte response serializer and its tx handshake.

Verification
REQ-035 Send 02 00 00 10 00 DE AD BE EF; pulse dbg_ready_i 3 cycles after dbg_valid_o -> dbg_cmd_o=02, dbg_addr_o=0x00001000, dbg_data_o=0xDEADBEEF held until ready; tx emits AC.
REQ-036 Send 01 00 00 00 04 with dbg_data_i=0x12345678 -> tx emits 12 34 56 78 in order, with tx_ready_i low 5 cycles before the 2nd byte and tx_data_o held stable throughout.
REQ-037 Send 7F -> tx emits EE; no dbg_valid_o pulse.
REQ-038 With TIMEOUT_CYCLES=20, send 02 00 then idle 20 cycles, then 01 00 00 00 08 -> no request for the first frame; READ to 0x00000008 is issued.
REQ-039 Assert rstn_i in WAIT -> all outputs are 0 immediately; a subsequent 01 00 00 00 00 frame completes normally.
REQ-040 Inject rx bytes during WAIT and RESP -> they are ignored and the response bytes are unchanged.
